// File: rtl/mdbrot_pixel_scheduler.sv
// mdbrot_pixel_scheduler
//   Frame-level controller for a Mandelbrot renderer. Walks the XRES x YRES
//   pixel grid in raster order, hands each coordinate to an idle escape-time
//   core, collects finished iteration counts through a round-robin arbiter
//   and serialises them onto a single registered VGA plot port.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   start, max_iter   frame request (sampled in IDLE) and iteration limit
//   busy, done        frame in progress / one-cycle completion pulse
//   core_ready        per-core idle indication
//   disp_valid/x/y    one-hot dispatch strobe with pixel coordinate
//   res_valid/iter    per-core finished result, counts packed ITW bits each
//   res_ack           one-hot result consume strobe
//   vga_x/y/colour    registered plot coordinate and colour
//   vga_plot          registered plot strobe
//
// Build option
//   MDBROT_SCHED_STATS_EN adds frame_cycles (clocks from start acceptance to
//   done) and max_iter_hits (pixels whose count equalled max_iter).

module mdbrot_pixel_scheduler #(
  parameter int NCORES = 4,
  parameter int XRES   = 160,
  parameter int YRES   = 120,
  parameter int ITW    = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITW-1:0]        max_iter,
  output logic                  busy,
  output logic                  done,
  input  logic [NCORES-1:0]     core_ready,
  output logic [NCORES-1:0]     disp_valid,
  output logic [7:0]            disp_x,
  output logic [6:0]            disp_y,
  input  logic [NCORES-1:0]     res_valid,
  input  logic [NCORES*ITW-1:0] res_iter,
  output logic [NCORES-1:0]     res_ack,
  output logic [7:0]            vga_x,
  output logic [6:0]            vga_y,
  output logic [2:0]            vga_colour,
  output logic                  vga_plot
`ifdef MDBROT_SCHED_STATS_EN
  ,
  output logic [31:0]           frame_cycles,
  output logic [14:0]           max_iter_hits
`endif
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int OW = $clog2(NCORES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_next;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [ITW-1:0]    max_iter_q;
  logic [PW-1:0]     rr_ptr;
  logic [OW-1:0]     outstanding;
  logic [NCORES-1:0] pending;
  logic [NCORES-1:0] last_disp;
  logic [NCORES-1:0] last_ack;
  logic [7:0]        tag_x [NCORES];
  logic [6:0]        tag_y [NCORES];

  logic              disp_any;
  logic [PW-1:0]     disp_sel;
  logic              grant_any;
  logic [PW-1:0]     grant_sel;
  logic [NCORES-1:0] eligible;
  logic [ITW-1:0]    sel_iter;
  logic              last_pixel;
  int                scan_int;
  logic [PW-1:0]     scan_idx;

  assign last_pixel = (x_q == 8'(XRES - 1)) && (y_q == 7'(YRES - 1));
  assign sel_iter   = res_iter[grant_sel*ITW +: ITW];

  // A core is a dispatch candidate only if it is ready, was not strobed last
  // cycle (its ready has not had time to fall) and holds no live tag.
  always_comb begin
    disp_any   = 1'b0;
    disp_sel   = '0;
    disp_valid = '0;
    if (state == S_RUN) begin
      for (int i = NCORES - 1; i >= 0; i--) begin
        if (core_ready[i] && !last_disp[i] && !pending[i]) begin
          disp_any = 1'b1;
          disp_sel = PW'(i);
        end
      end
    end
    if (disp_any) disp_valid[disp_sel] = 1'b1;
    disp_x = disp_any ? x_q : 8'd0;
    disp_y = disp_any ? y_q : 7'd0;
  end

  // Round-robin search starting at rr_ptr. Results from cores without a live
  // tag are ignored, and a core acked last cycle is skipped because its
  // res_valid is still visible for that one cycle.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = '0;
    res_ack   = '0;
    scan_int  = 0;
    scan_idx  = '0;
    eligible  = '0;
    if (state == S_RUN || state == S_DRAIN)
      eligible = res_valid & pending & ~last_ack;
    for (int k = 0; k < NCORES; k++) begin
      scan_int = int'(rr_ptr) + k;
      if (scan_int >= NCORES) scan_int = scan_int - NCORES;
      scan_idx = PW'(scan_int);
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_sel = scan_idx;
      end
    end
    if (grant_any) res_ack[grant_sel] = 1'b1;
  end

  // Frame sequencing. DRAIN exits once nothing is outstanding, which also
  // means no grant is feeding the plot register, so done lands exactly one
  // cycle after the final plot.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (disp_any && last_pixel) state_next = S_DRAIN;
      S_DRAIN: if (outstanding == '0 && !grant_any) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Scan counters, tag registers, arbitration bookkeeping and the plot stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      max_iter_q  <= '0;
      rr_ptr      <= '0;
      outstanding <= '0;
      pending     <= '0;
      last_disp   <= '0;
      last_ack    <= '0;
      vga_plot    <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      for (int i = 0; i < NCORES; i++) begin
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
    end else begin
      state     <= state_next;
      last_disp <= disp_valid;
      last_ack  <= res_ack;
      pending   <= (pending | disp_valid) & ~res_ack;
      outstanding <= outstanding + OW'(disp_any) - OW'(grant_any);

      if (state == S_IDLE && start) begin
        max_iter_q <= max_iter;
        x_q        <= '0;
        y_q        <= '0;
      end

      if (disp_any) begin
        tag_x[disp_sel] <= x_q;
        tag_y[disp_sel] <= y_q;
        if (x_q == 8'(XRES - 1)) begin
          x_q <= '0;
          y_q <= y_q + 7'd1;
        end else begin
          x_q <= x_q + 8'd1;
        end
      end

      if (grant_any)
        rr_ptr <= (grant_sel == PW'(NCORES - 1)) ? '0 : grant_sel + 1'b1;

      vga_plot   <= grant_any;
      vga_x      <= grant_any ? tag_x[grant_sel] : 8'd0;
      vga_y      <= grant_any ? tag_y[grant_sel] : 7'd0;
      vga_colour <= (grant_any && sel_iter != max_iter_q) ? sel_iter[2:0] : 3'd0;
    end
  end

`ifdef MDBROT_SCHED_STATS_EN
  // frame_cycles runs through the DONE cycle so it equals the number of
  // clocks from the accepting edge to the edge that raised done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cycles  <= '0;
      max_iter_hits <= '0;
    end else if (state == S_IDLE && start) begin
      frame_cycles  <= '0;
      max_iter_hits <= '0;
    end else begin
      if (state != S_IDLE) frame_cycles <= frame_cycles + 32'd1;
      if (grant_any && sel_iter == max_iter_q) max_iter_hits <= max_iter_hits + 15'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mdbrot_pixel_scheduler.sv
// tb_mdbrot_pixel_scheduler
//   Drives mdbrot_pixel_scheduler with a set of behavioural cores (random
//   latencies and iteration counts) and checks every dispatch, ack, plot and
//   done pulse of each frame against a reference picture of the frame.

module tb_mdbrot_pixel_scheduler;

  localparam int NC   = 4;
  localparam int XR   = 6;
  localparam int YR   = 3;
  localparam int IW   = 13;
  localparam int NPIX = XR * YR;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [IW-1:0]      max_iter = '0;
  logic               busy, done;
  logic [NC-1:0]      core_ready;
  logic [NC-1:0]      disp_valid;
  logic [7:0]         disp_x;
  logic [6:0]         disp_y;
  logic [NC-1:0]      res_valid;
  logic [NC*IW-1:0]   res_iter;
  logic [NC-1:0]      res_ack;
  logic [7:0]         vga_x;
  logic [6:0]         vga_y;
  logic [2:0]         vga_colour;
  logic               vga_plot;
`ifdef MDBROT_SCHED_STATS_EN
  logic [31:0]        frame_cycles;
  logic [14:0]        max_iter_hits;
`endif

  mdbrot_pixel_scheduler #(.NCORES(NC), .XRES(XR), .YRES(YR), .ITW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
    .busy(busy), .done(done), .core_ready(core_ready),
    .disp_valid(disp_valid), .disp_x(disp_x), .disp_y(disp_y),
    .res_valid(res_valid), .res_iter(res_iter), .res_ack(res_ack),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
`ifdef MDBROT_SCHED_STATS_EN
    ,
    .frame_cycles(frame_cycles), .max_iter_hits(max_iter_hits)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus-side configuration (written by the main sequence only).
  logic [NC-1:0] en_mask = '1;
  int            lat [NC];
  bit            hold = 1'b0;
  logic [IW-1:0] iter_tab [NPIX];

  // Behavioural core state (written by the core model only).
  logic [NC-1:0] ready_r = '1;
  logic [NC-1:0] valid_r = '0;
  logic [IW-1:0] it_r [NC];
  bit            comp [NC];
  int            cnt [NC];
  logic [7:0]    mtx [NC];
  logic [6:0]    mty [NC];

  assign core_ready = ready_r & en_mask;
  assign res_valid  = valid_r;
  always_comb begin
    res_iter = '0;
    for (int i = 0; i < NC; i++) res_iter[i*IW +: IW] = it_r[i];
  end

  typedef struct { int cyc; logic [NC-1:0] vec; logic [NC-1:0] ready; logic [NC-1:0] prev;
                   logic [7:0] x; logic [6:0] y; } disp_t;
  typedef struct { int cyc; logic [NC-1:0] vec; logic [NC-1:0] rvalid; int core;
                   logic [7:0] x; logic [6:0] y; } ack_t;
  typedef struct { int cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c; } plot_t;

  disp_t disp_q [$];
  ack_t  ack_q  [$];
  plot_t plot_q [$];
  int    done_q [$];

  int            cyc_n = 0;
  logic [NC-1:0] prev_disp = '0;
  logic [NC-1:0] snap_disp, snap_ack;
  logic [7:0]    snap_x;
  logic [6:0]    snap_y;
  logic          snap_rst;
  disp_t         de;
  ack_t          ae;
  plot_t         pe;

  int total = 0;
  int bad   = 0;

  function automatic int lowest(input logic [NC-1:0] v);
    int r = -1;
    for (int i = NC - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [2:0] colour_of(input logic [IW-1:0] it, input logic [IW-1:0] mx);
    return (it == mx) ? 3'd0 : 3'(it % 8);
  endfunction

  // Event logger and core model: observe at the falling edge, react just
  // after the rising edge so inputs never change on the sampling edge.
  always begin
    @(negedge clk);
    cyc_n = cyc_n + 1;
    if (disp_valid != '0) begin
      de.cyc = cyc_n; de.vec = disp_valid; de.ready = core_ready; de.prev = prev_disp;
      de.x = disp_x; de.y = disp_y;
      disp_q.push_back(de);
    end
    prev_disp = disp_valid;
    if (res_ack != '0) begin
      ae.cyc = cyc_n; ae.vec = res_ack; ae.rvalid = res_valid; ae.core = lowest(res_ack);
      ae.x = mtx[ae.core]; ae.y = mty[ae.core];
      ack_q.push_back(ae);
    end
    if (vga_plot) begin
      pe.cyc = cyc_n; pe.x = vga_x; pe.y = vga_y; pe.c = vga_colour;
      plot_q.push_back(pe);
    end
    if (done) done_q.push_back(cyc_n);
    snap_disp = disp_valid; snap_ack = res_ack; snap_x = disp_x; snap_y = disp_y; snap_rst = rst;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (!snap_rst) begin
        ready_r[i] = 1'b1; valid_r[i] = 1'b0; comp[i] = 1'b0; cnt[i] = 0; it_r[i] = '0;
      end else begin
        if (snap_ack[i]) begin
          valid_r[i] = 1'b0; ready_r[i] = 1'b1;
        end
        if (snap_disp[i]) begin
          ready_r[i] = 1'b0; comp[i] = 1'b1; cnt[i] = lat[i]; mtx[i] = snap_x; mty[i] = snap_y;
        end else if (comp[i]) begin
          if (cnt[i] > 1) cnt[i] = cnt[i] - 1;
          else if (!hold) begin
            comp[i] = 1'b0; valid_r[i] = 1'b1;
            it_r[i] = iter_tab[int'(mty[i]) * XR + int'(mtx[i])];
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [IW-1:0] mx, input bit hold_start,
                               input int release_after, output int meas,
                               output int d0, output int a0, output int p0, output int n0);
    int  cyc = 0;
    bit  seen_done = 1'b0;
    d0 = disp_q.size(); a0 = ack_q.size(); p0 = plot_q.size(); n0 = done_q.size();
    @(negedge clk);
    max_iter = mx;
    start = 1'b1;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({name, "_busy_on"}, busy, 1);
      if (!hold_start && cyc == 1) start = 1'b0;
      if (cyc == release_after) hold = 1'b0;
      if (done) seen_done = 1'b1;
    end
    start = 1'b0;
    hold  = 1'b0;
    check({name, "_done_seen"}, seen_done, 1);
    meas = cyc;
    repeat (3) @(negedge clk);
    check({name, "_busy_off"}, busy, 0);
  endtask

  task automatic checkOutput(input string name, input logic [IW-1:0] mx, input int meas,
                             input int d0, input int a0, input int p0, input int n0,
                             output bit ooo);
    int nd = disp_q.size() - d0;
    int na = ack_q.size() - a0;
    int np = plot_q.size() - p0;
    int seen [NPIX];
    int hits = 0;
    int last = -1;
    int idx;
    ooo = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      seen[k] = 0;
      if (iter_tab[k] == mx) hits++;
    end
    check({name, "_disp_count"}, nd, NPIX);
    for (int k = 0; k < nd && k < NPIX; k++) begin
      disp_t e = disp_q[d0 + k];
      check({name, "_disp_onehot"}, $countones(e.vec), 1);
      check({name, "_disp_x"}, e.x, k % XR);
      check({name, "_disp_y"}, e.y, k / XR);
      check({name, "_disp_target"}, lowest(e.vec), lowest(e.ready & ~e.prev));
    end
    check({name, "_ack_count"}, na, NPIX);
    for (int k = 0; k < na; k++) begin
      ack_t e = ack_q[a0 + k];
      check({name, "_ack_onehot"}, $countones(e.vec), 1);
      check({name, "_ack_valid"}, e.rvalid[e.core], 1);
      if (k > 0)
        check({name, "_ack_repeat"}, (ack_q[a0+k-1].core == e.core) && (ack_q[a0+k-1].cyc + 1 == e.cyc), 0);
    end
    check({name, "_plot_count"}, np, NPIX);
    for (int k = 0; k < np && k < na; k++) begin
      plot_t p = plot_q[p0 + k];
      ack_t  a = ack_q[a0 + k];
      check({name, "_plot_latency"}, p.cyc, a.cyc + 1);
      check({name, "_plot_x"}, p.x, a.x);
      check({name, "_plot_y"}, p.y, a.y);
      if (int'(p.x) < XR && int'(p.y) < YR) begin
        idx = int'(p.y) * XR + int'(p.x);
        check({name, "_plot_colour"}, p.c, colour_of(iter_tab[idx], mx));
        check({name, "_plot_unique"}, seen[idx], 0);
        seen[idx]++;
        if (idx < last) ooo = 1'b1;
        last = idx;
      end else begin
        check({name, "_plot_range"}, 0, 1);
      end
    end
    check({name, "_done_pulses"}, done_q.size() - n0, 1);
    if (done_q.size() - n0 == 1 && np > 0)
      check({name, "_done_timing"}, done_q[n0], plot_q[plot_q.size()-1].cyc + 1);
`ifdef MDBROT_SCHED_STATS_EN
    check({name, "_frame_cycles"}, frame_cycles, meas);
    check({name, "_max_iter_hits"}, max_iter_hits, hits);
`else
    if (meas < 0) check({name, "_meas"}, meas, 0);
`endif
  endtask

  task automatic fill_random(input logic [IW-1:0] mx);
    for (int k = 0; k < NPIX; k++)
      iter_tab[k] = ($urandom_range(0, 3) == 0) ? mx : IW'($urandom_range(0, int'(mx) - 1));
  endtask

  initial begin
    int meas, d0, a0, p0, n0;
    bit ooo;

    for (int i = 0; i < NC; i++) lat[i] = 3;
    for (int k = 0; k < NPIX; k++) iter_tab[k] = '0;

    // Reset state.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_disp", disp_valid, 0);
    check("rst_ack", res_ack, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_vga_xyc", {vga_x, vga_y, vga_colour}, 0);
`ifdef MDBROT_SCHED_STATS_EN
    check("rst_stats", {frame_cycles, max_iter_hits}, 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // All four cores complete together: grants must run 0,1,2,3 back to back.
    hold = 1'b1;
    fill_random(13'd50);
    applyStimulus("rr", 13'd50, 1'b0, 15, meas, d0, a0, p0, n0);
    checkOutput("rr", 13'd50, meas, d0, a0, p0, n0, ooo);
    for (int k = 0; k < NC; k++) begin
      check("rr_order", ack_q[a0 + k].core, k);
      check("rr_consecutive", ack_q[a0 + k].cyc, ack_q[a0].cyc + k);
    end

    // Single core, fixed latency, every pixel returns 3.
    en_mask = 4'b0001;
    lat[0] = 5;
    for (int k = 0; k < NPIX; k++) iter_tab[k] = 13'd3;
    applyStimulus("single", 13'd100, 1'b0, 0, meas, d0, a0, p0, n0);
    checkOutput("single", 13'd100, meas, d0, a0, p0, n0, ooo);

    // Colour mapping with max_iter=20: counts 20, 13 and 0 in rotation.
    en_mask = '1;
    for (int i = 0; i < NC; i++) lat[i] = $urandom_range(2, 6);
    for (int k = 0; k < NPIX; k++) iter_tab[k] = (k % 3 == 0) ? 13'd20 : (k % 3 == 1) ? 13'd13 : 13'd0;
    applyStimulus("colour", 13'd20, 1'b0, 0, meas, d0, a0, p0, n0);
    checkOutput("colour", 13'd20, meas, d0, a0, p0, n0, ooo);

    // Slow core 0: results come back out of raster order.
    lat[0] = 50;
    for (int i = 1; i < NC; i++) lat[i] = 3;
    fill_random(13'd200);
    applyStimulus("slow", 13'd200, 1'b0, 0, meas, d0, a0, p0, n0);
    checkOutput("slow", 13'd200, meas, d0, a0, p0, n0, ooo);
    check("slow_out_of_order", ooo, 1);

    // start held high for the whole frame must not restart the scan.
    for (int i = 0; i < NC; i++) lat[i] = $urandom_range(1, 8);
    fill_random(13'd31);
    applyStimulus("hold_start", 13'd31, 1'b1, 0, meas, d0, a0, p0, n0);
    checkOutput("hold_start", 13'd31, meas, d0, a0, p0, n0, ooo);

    // Reset in the middle of a frame, then a clean frame from (0,0).
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_disp", {disp_valid, disp_x, disp_y}, 0);
    check("midrst_ack", res_ack, 0);
    check("midrst_vga", {vga_plot, vga_x, vga_y, vga_colour}, 0);
    rst = 1'b1;
    @(negedge clk);
    fill_random(13'd64);
    applyStimulus("after_rst", 13'd64, 1'b0, 0, meas, d0, a0, p0, n0);
    checkOutput("after_rst", 13'd64, meas, d0, a0, p0, n0, ooo);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
